game_over_overlay: RTL and testbench

GAME_OVER_OVERLAY -- requirements
Module: game_over_overlay

---
 rtl/game_over_overlay.sv | 172 +++++++++++++++++
 tb/tb_game_over_overlay.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_over_overlay.sv
// Game-over overlay: freezes play, draws a blinking box over the video stream
// at the next frame start, and issues one restart pulse on a fresh key press.
module game_over_overlay #(
  parameter int          HOR_PIX      = 1024,
  parameter int          VER_PIX      = 768,
  parameter int          BOX_X        = 384,
  parameter int          BOX_Y        = 352,
  parameter int          BOX_W        = 256,
  parameter int          BOX_H        = 64,
  parameter int          BORDER       = 4,
  parameter logic [11:0] BOX_COLOR    = 12'hF00,
  parameter int          BLINK_FRAMES = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        hblnk_in,
  input  logic        vsync_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  input  logic        game_over,
  input  logic        restart_key,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        hblnk_out,
  output logic        vsync_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out,
  output logic        freeze,
  output logic        restart,
  // Debug view: state encoding PLAY=0, WAIT_FRAME=1, SHOW=2, RELEASE=3
  output logic [1:0]  dbg_state,
  output logic        dbg_blink_on
);

  typedef enum logic [1:0] {
    ST_PLAY       = 2'd0,
    ST_WAIT_FRAME = 2'd1,
    ST_SHOW       = 2'd2,
    ST_RELEASE    = 2'd3
  } state_t;

  // Box edges widened to 12 bits so BOX_X+BOX_W never wraps against 11-bit counters
  localparam logic [11:0] X_LO  = 12'(BOX_X);
  localparam logic [11:0] X_HI  = 12'(BOX_X + BOX_W);
  localparam logic [11:0] Y_LO  = 12'(BOX_Y);
  localparam logic [11:0] Y_HI  = 12'(BOX_Y + BOX_H);
  localparam logic [11:0] XB_LO = 12'(BOX_X + BORDER);
  localparam logic [11:0] XB_HI = 12'(BOX_X + BOX_W - BORDER);
  localparam logic [11:0] YB_LO = 12'(BOX_Y + BORDER);
  localparam logic [11:0] YB_HI = 12'(BOX_Y + BOX_H - BORDER);
  localparam logic [11:0] H_MAX = 12'(HOR_PIX);
  localparam logic [11:0] V_MAX = 12'(VER_PIX);
  localparam logic [5:0]  BLINK_LAST = 6'(BLINK_FRAMES - 1);

  state_t      r_state;
  state_t      w_next_state;
  logic [5:0]  r_blink_cnt;
  logic [5:0]  w_blink_cnt_next;
  logic        r_blink_on;
  logic        w_blink_on_next;
  logic        r_vsync_prev;
  logic        r_key_prev;
  logic        w_frame_start;
  logic        w_key_edge;
  logic        w_restart_next;
  logic [11:0] w_h;
  logic [11:0] w_v;
  logic        w_in_box;
  logic        w_border;
  logic [11:0] w_rgb_next;

  assign w_frame_start = vsync_in & ~r_vsync_prev;
  assign w_key_edge    = restart_key & ~r_key_prev;

  assign w_h = {1'b0, hcount_in};
  assign w_v = {1'b0, vcount_in};

  assign w_in_box = (w_h >= X_LO) && (w_h < X_HI) && (w_h < H_MAX) &&
                    (w_v >= Y_LO) && (w_v < Y_HI) && (w_v < V_MAX) &&
                    !hblnk_in && !vblnk_in;

  assign w_border = (w_h < XB_LO) || (w_h >= XB_HI) ||
                    (w_v < YB_LO) || (w_v >= YB_HI);

  always_comb begin
    w_next_state     = r_state;
    w_blink_cnt_next = r_blink_cnt;
    w_blink_on_next  = r_blink_on;
    w_restart_next   = 1'b0;
    case (r_state)
      ST_PLAY: begin
        if (game_over) w_next_state = ST_WAIT_FRAME;
      end
      ST_WAIT_FRAME: begin
        if (w_frame_start) begin
          w_next_state     = ST_SHOW;
          w_blink_cnt_next = 6'd0;
          w_blink_on_next  = 1'b1;
        end
      end
      ST_SHOW: begin
        // A key edge wins over a coincident frame start; the blink step is dropped
        if (w_key_edge) begin
          w_next_state   = ST_RELEASE;
          w_restart_next = 1'b1;
        end else if (w_frame_start) begin
          if (r_blink_cnt == BLINK_LAST) begin
            w_blink_cnt_next = 6'd0;
            w_blink_on_next  = ~r_blink_on;
          end else begin
            w_blink_cnt_next = r_blink_cnt + 6'd1;
          end
        end
      end
      ST_RELEASE: begin
        if (!game_over) w_next_state = ST_PLAY;
      end
      default: w_next_state = ST_PLAY;
    endcase
  end

  always_comb begin
    w_rgb_next = rgb_in;
    if ((r_state == ST_SHOW) && w_in_box) begin
      if (w_border)        w_rgb_next = BOX_COLOR;
      else if (r_blink_on) w_rgb_next = 12'hFFF;
      else                 w_rgb_next = 12'h000;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_PLAY;
      r_blink_cnt  <= 6'd0;
      r_blink_on   <= 1'b0;
      r_vsync_prev <= 1'b0;
      r_key_prev   <= 1'b0;
      hcount_out   <= 11'd0;
      vcount_out   <= 11'd0;
      hsync_out    <= 1'b0;
      hblnk_out    <= 1'b0;
      vsync_out    <= 1'b0;
      vblnk_out    <= 1'b0;
      rgb_out      <= 12'h000;
      freeze       <= 1'b0;
      restart      <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_blink_cnt  <= w_blink_cnt_next;
      r_blink_on   <= w_blink_on_next;
      r_vsync_prev <= vsync_in;
      r_key_prev   <= restart_key;
      hcount_out   <= hcount_in;
      vcount_out   <= vcount_in;
      hsync_out    <= hsync_in;
      hblnk_out    <= hblnk_in;
      vsync_out    <= vsync_in;
      vblnk_out    <= vblnk_in;
      rgb_out      <= w_rgb_next;
      freeze       <= (w_next_state != ST_PLAY);
      restart      <= w_restart_next;
    end
  end

  assign dbg_state    = r_state;
  assign dbg_blink_on = r_blink_on;

endmodule

// File: tb/tb_game_over_overlay.sv
// Bench for game_over_overlay: scenario tasks driven cycle by cycle and
// checked against a frame-counting reference model.
module tb_game_over_overlay;

  localparam int BX = 384, BY = 352, BW = 256, BH = 64, BORD = 4;
  localparam int HP = 1024, VP = 768, BF = 2;
  localparam logic [11:0] COL = 12'hF00;
  localparam int M_PLAY = 0, M_WAIT = 1, M_SHOW = 2, M_REL = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [10:0] hcount_in = '0, vcount_in = '0;
  logic        hsync_in = 1'b0, hblnk_in = 1'b0, vsync_in = 1'b0, vblnk_in = 1'b0;
  logic [11:0] rgb_in = '0;
  logic        game_over = 1'b0, restart_key = 1'b0;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, hblnk_out, vsync_out, vblnk_out;
  logic [11:0] rgb_out;
  logic        freeze, restart;
  logic [1:0]  dbg_state;
  logic        dbg_blink_on;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: mode plus number of frame starts seen since entering SHOW
  int m_mode = M_PLAY;
  int m_frames = 0;
  bit m_prev_vs = 0, m_prev_key = 0;

  logic [11:0] exp_rgb;
  logic        exp_freeze, exp_restart;
  logic [25:0] exp_timing;

  game_over_overlay #(.BLINK_FRAMES(BF)) dut (
    .clk(clk), .rst(rst),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .hblnk_in(hblnk_in), .vsync_in(vsync_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .game_over(game_over), .restart_key(restart_key),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .hblnk_out(hblnk_out), .vsync_out(vsync_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out), .freeze(freeze), .restart(restart),
    .dbg_state(dbg_state), .dbg_blink_on(dbg_blink_on)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [10:0] rand_h();
    if ($urandom_range(0, 3) != 0) return 11'($urandom_range(BX - 8, BX + BW + 8));
    return 11'($urandom_range(0, 2047));
  endfunction

  function automatic logic [10:0] rand_v();
    if ($urandom_range(0, 3) != 0) return 11'($urandom_range(BY - 8, BY + BH + 8));
    return 11'($urandom_range(0, 2047));
  endfunction

  task automatic model_reset();
    m_mode = M_PLAY;
    m_frames = 0;
    m_prev_vs = 0;
    m_prev_key = 0;
  endtask

  function automatic bit model_blink_on();
    return ((m_frames / BF) % 2) == 0;
  endfunction

  // Drive one pixel cycle, predict the registered outputs, advance past the edge
  task automatic drive_cycle(input logic [10:0] h, input logic [10:0] v, input logic [11:0] rgb,
                             input logic go, input logic key, input logic vs,
                             input logic hb, input logic vb);
    int  hi, vi;
    bit  in_box, border, fs, ke;
    hcount_in = h; vcount_in = v; rgb_in = rgb;
    game_over = go; restart_key = key; vsync_in = vs;
    hblnk_in = hb; vblnk_in = vb; hsync_in = 1'($urandom_range(0, 1));
    hi = int'(h); vi = int'(v);
    in_box = hi >= BX && hi < BX + BW && hi < HP && vi >= BY && vi < BY + BH && vi < VP && !hb && !vb;
    border = hi < BX + BORD || hi >= BX + BW - BORD || vi < BY + BORD || vi >= BY + BH - BORD;
    fs = vs && !m_prev_vs;
    ke = key && !m_prev_key;
    exp_rgb = rgb;
    if (m_mode == M_SHOW && in_box)
      exp_rgb = border ? COL : (model_blink_on() ? 12'hFFF : 12'h000);
    exp_restart = (m_mode == M_SHOW) && ke;
    exp_timing = {h, v, hsync_in, hb, vs, vb};
    case (m_mode)
      M_PLAY: if (go) m_mode = M_WAIT;
      M_WAIT: if (fs) begin m_mode = M_SHOW; m_frames = 0; end
      M_SHOW: if (ke) m_mode = M_REL; else if (fs) m_frames++;
      default: if (!go) m_mode = M_PLAY;
    endcase
    exp_freeze = (m_mode != M_PLAY);
    m_prev_vs = vs;
    m_prev_key = key;
    @(posedge clk);
    #1;
  endtask

  // Two blanked cycles with vsync high, then vsync low again
  task automatic frame_pulse(input logic go, input logic key);
    drive_cycle(11'd0, 11'd0, 12'h000, go, key, 1'b1, 1'b1, 1'b1);
    drive_cycle(11'd1, 11'd0, 12'h000, go, key, 1'b1, 1'b1, 1'b1);
    drive_cycle(11'd2, 11'd0, 12'h000, go, key, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    hcount_in = 11'd77; vcount_in = 11'd88; rgb_in = 12'hABC;
    hsync_in = 1'b1; hblnk_in = 1'b1; vsync_in = 1'b1; vblnk_in = 1'b1;
    game_over = 1'b1; restart_key = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (rgb_out !== 12'h000) begin tests_failed++; $display("FAIL reset_rgb: got %h want 000", rgb_out); end
    tests_run++;
    if ({freeze, restart} !== 2'b00) begin tests_failed++; $display("FAIL reset_ctl: got %b want 00", {freeze, restart}); end
    tests_run++;
    if ({hcount_out, vcount_out, hsync_out, hblnk_out, vsync_out, vblnk_out} !== 26'd0) begin
      tests_failed++; $display("FAIL reset_timing: got %h want 0", {hcount_out, vcount_out, hsync_out, hblnk_out, vsync_out, vblnk_out});
    end
    tests_run++;
    if ({dbg_state, dbg_blink_on} !== 3'd0) begin tests_failed++; $display("FAIL reset_dbg: got %b want 000", {dbg_state, dbg_blink_on}); end
    game_over = 1'b0; restart_key = 1'b0; vsync_in = 1'b0;
    rst = 1'b1;
    model_reset();
  endtask

  task automatic test_pass_through();
    drive_cycle(11'd100, 11'd100, 12'h0A5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if (rgb_out !== 12'h0A5) begin tests_failed++; $display("FAIL pass_rgb: got %h want 0a5", rgb_out); end
    tests_run++;
    if (hcount_out !== 11'd100) begin tests_failed++; $display("FAIL pass_hcount: got %0d want 100", hcount_out); end
    tests_run++;
    if (freeze !== 1'b0) begin tests_failed++; $display("FAIL pass_freeze: got %b want 0", freeze); end
    for (int i = 0; i < 40; i++) begin
      drive_cycle(rand_h(), rand_v(), 12'($urandom), 1'b0, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'b0, 1'b0);
      tests_run++;
      if ({rgb_out, freeze, restart} !== {exp_rgb, exp_freeze, exp_restart}) begin
        tests_failed++; $display("FAIL pass_rand: got %h/%b/%b want %h/%b/%b", rgb_out, freeze, restart, exp_rgb, exp_freeze, exp_restart);
      end
      tests_run++;
      if ({hcount_out, vcount_out, hsync_out, hblnk_out, vsync_out, vblnk_out} !== exp_timing) begin
        tests_failed++; $display("FAIL pass_timing: got %h want %h", {hcount_out, vcount_out, hsync_out, hblnk_out, vsync_out, vblnk_out}, exp_timing);
      end
    end
  endtask

  task automatic test_entry();
    logic [11:0] c;
    drive_cycle(11'd200, 11'd300, 12'h123, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if (freeze !== 1'b1) begin tests_failed++; $display("FAIL entry_freeze: got %b want 1", freeze); end
    for (int i = 0; i < 5; i++) begin
      c = 12'($urandom);
      drive_cycle(11'd500, 11'd380, c, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      tests_run++;
      if (rgb_out !== c) begin tests_failed++; $display("FAIL entry_no_overlay: got %h want %h", rgb_out, c); end
    end
    frame_pulse(1'b0, 1'b0);
    drive_cycle(11'd384, 11'd352, 12'h0F0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if (rgb_out !== 12'hF00) begin tests_failed++; $display("FAIL entry_border: got %h want f00", rgb_out); end
    drive_cycle(11'd500, 11'd380, 12'h0F0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if (rgb_out !== 12'hFFF) begin tests_failed++; $display("FAIL entry_interior: got %h want fff", rgb_out); end
    tests_run++;
    if (freeze !== 1'b1) begin tests_failed++; $display("FAIL entry_hold_freeze: got %b want 1", freeze); end
    drive_cycle(11'd640, 11'd380, 12'h0F0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if (rgb_out !== 12'h0F0) begin tests_failed++; $display("FAIL entry_right_edge: got %h want 0f0", rgb_out); end
    drive_cycle(11'd639, 11'd415, 12'h0F0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if (rgb_out !== 12'hF00) begin tests_failed++; $display("FAIL entry_last_px: got %h want f00", rgb_out); end
    drive_cycle(11'd500, 11'd380, 12'h0F0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tests_run++;
    if (rgb_out !== 12'h0F0) begin tests_failed++; $display("FAIL entry_hblank: got %h want 0f0", rgb_out); end
  endtask

  task automatic test_blink();
    logic [11:0] want;
    for (int f = 0; f < 8; f++) begin
      want = (((f / 2) % 2) == 0) ? 12'hFFF : 12'h000;
      drive_cycle(11'd450, 11'd370, 12'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tests_run++;
      if (rgb_out !== want) begin tests_failed++; $display("FAIL blink_f%0d: got %h want %h", f, rgb_out, want); end
      for (int i = 0; i < 4; i++) begin
        drive_cycle(rand_h(), rand_v(), 12'($urandom), 1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
        tests_run++;
        if ({rgb_out, freeze} !== {exp_rgb, exp_freeze}) begin
          tests_failed++; $display("FAIL blink_rand: got %h/%b want %h/%b", rgb_out, freeze, exp_rgb, exp_freeze);
        end
      end
      frame_pulse(1'b0, 1'b0);
    end
  endtask

  task automatic test_simultaneous();
    bit on_before;
    repeat (3) frame_pulse(1'b1, 1'b0);
    drive_cycle(11'd450, 11'd370, 12'h456, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if (rgb_out !== exp_rgb) begin tests_failed++; $display("FAIL sim_pre_rgb: got %h want %h", rgb_out, exp_rgb); end
    on_before = model_blink_on();
    drive_cycle(11'd0, 11'd0, 12'h000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    tests_run++;
    if (restart !== 1'b1) begin tests_failed++; $display("FAIL sim_restart: got %b want 1", restart); end
    tests_run++;
    if (dbg_state !== 2'd3) begin tests_failed++; $display("FAIL sim_state: got %0d want 3", dbg_state); end
    tests_run++;
    if (dbg_blink_on !== on_before) begin tests_failed++; $display("FAIL sim_blink: got %b want %b", dbg_blink_on, on_before); end
    drive_cycle(11'd450, 11'd370, 12'h789, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if ({rgb_out, freeze, restart} !== {12'h789, 1'b1, 1'b0}) begin
      tests_failed++; $display("FAIL sim_release: got %h/%b/%b want 789/1/0", rgb_out, freeze, restart);
    end
    drive_cycle(11'd450, 11'd370, 12'h789, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if ({freeze, dbg_state} !== 3'b000) begin tests_failed++; $display("FAIL sim_play: got %b/%0d want 0/0", freeze, dbg_state); end
  endtask

  task automatic test_restart();
    int pulses;
    drive_cycle(11'd10, 11'd10, 12'h111, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    frame_pulse(1'b1, 1'b1);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      drive_cycle(rand_h(), rand_v(), 12'($urandom), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      tests_run++;
      if (restart !== 1'b0) begin tests_failed++; $display("FAIL rst_held: got %b want 0", restart); end
    end
    drive_cycle(11'd10, 11'd10, 12'h111, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive_cycle(11'd10, 11'd10, 12'h111, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if (restart !== 1'b0) begin tests_failed++; $display("FAIL rst_released: got %b want 0", restart); end
    for (int i = 0; i < 4; i++) begin
      drive_cycle(11'd10, 11'd10, 12'h111, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      if (restart === 1'b1) pulses++;
      tests_run++;
      if (restart !== (i == 0)) begin tests_failed++; $display("FAIL rst_pulse_c%0d: got %b want %b", i, restart, (i == 0)); end
    end
    tests_run++;
    if (pulses != 1) begin tests_failed++; $display("FAIL rst_pulse_count: got %0d want 1", pulses); end
    drive_cycle(11'd10, 11'd10, 12'h111, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive_cycle(11'd10, 11'd10, 12'h111, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if ({freeze, restart} !== 2'b10) begin tests_failed++; $display("FAIL rst_release_press: got %b want 10", {freeze, restart}); end
    drive_cycle(11'd10, 11'd10, 12'h111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if (freeze !== 1'b0) begin tests_failed++; $display("FAIL rst_unfreeze: got %b want 0", freeze); end
  endtask

  task automatic test_reset_mid_show();
    logic [11:0] c;
    drive_cycle(11'd10, 11'd10, 12'h111, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    frame_pulse(1'b1, 1'b0);
    drive_cycle(11'd384, 11'd352, 12'h222, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if ({rgb_out, freeze} !== {12'hF00, 1'b1}) begin tests_failed++; $display("FAIL mid_pre: got %h/%b want f00/1", rgb_out, freeze); end
    #2 rst = 1'b0;
    #1;
    tests_run++;
    if ({rgb_out, freeze, restart} !== 14'd0) begin
      tests_failed++; $display("FAIL mid_async: got %h/%b/%b want 000/0/0", rgb_out, freeze, restart);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    model_reset();
    c = 12'($urandom);
    drive_cycle(11'd500, 11'd380, c, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if ({rgb_out, freeze} !== {c, 1'b0}) begin tests_failed++; $display("FAIL mid_resume: got %h/%b want %h/0", rgb_out, freeze, c); end
  endtask

  task automatic test_random();
    logic go, key, vs;
    go = 1'b0; key = 1'b0; vs = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) go = ~go;
      if ($urandom_range(0, 5) == 0) key = ~key;
      if ($urandom_range(0, 9) == 0) vs = ~vs;
      drive_cycle(rand_h(), rand_v(), 12'($urandom), go, key, vs,
                  1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) == 0));
      tests_run++;
      if ({rgb_out, freeze, restart} !== {exp_rgb, exp_freeze, exp_restart}) begin
        tests_failed++; $display("FAIL rand_c%0d: got %h/%b/%b want %h/%b/%b", i, rgb_out, freeze, restart, exp_rgb, exp_freeze, exp_restart);
      end
      tests_run++;
      if ({hcount_out, vcount_out, hsync_out, hblnk_out, vsync_out, vblnk_out} !== exp_timing) begin
        tests_failed++; $display("FAIL rand_timing_c%0d: got %h want %h", i, {hcount_out, vcount_out, hsync_out, hblnk_out, vsync_out, vblnk_out}, exp_timing);
      end
    end
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_entry();
    test_blink();
    test_simultaneous();
    test_restart();
    test_reset_mid_show();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
